// File: rtl/edge_det_multi_if.sv
// Channel bundle for edge_det_multi: control and raw inputs in, pulses and counts out.
// Parameters must match those of the edge_det_multi instance it is bound to.
interface edge_det_multi_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
);
  logic                 ce;
  logic [NCH-1:0]       in_x;
  logic [2*NCH-1:0]     mode;
  logic                 cnt_clr;
  logic [NCH-1:0]       out_x;
  logic [NCH*CNT_W-1:0] edge_cnt;

  modport master (
    output ce, in_x, mode, cnt_clr,
    input  out_x, edge_cnt
  );

  modport slave (
    input  ce, in_x, mode, cnt_clr,
    output out_x, edge_cnt
  );
endinterface

// File: rtl/edge_det_multi.sv
// Multi-channel edge detector: optional synchroniser, per-channel mode, retriggerable
// pulse stretcher and saturating event counter, all qualified by a shared clock enable.
module edge_det_multi #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 1,
  parameter int CNT_W       = 8
) (
  input logic            clk,
  input logic            rst_n,
  edge_det_multi_if.slave bus
);
  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam int STR_W  = (STRETCH < 1) ? 1 : $clog2(STRETCH + 1);

  logic [NCH-1:0]    w_s;
  logic [NCH-1:0]    r_prev;
  logic [WARM_W-1:0] r_warm;
  logic              w_warm_done;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = bus.in_x;
    end else begin : g_sync
      logic [NCH-1:0] r_sync [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int j = 0; j < SYNC_STAGES; j++) r_sync[j] <= '0;
        end else if (bus.ce) begin
          r_sync[0] <= bus.in_x;
          for (int j = 1; j < SYNC_STAGES; j++) r_sync[j] <= r_sync[j-1];
        end
      end

      assign w_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Warm-up hides the first synchronised samples so a level already high at reset release is not seen as an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_warm <= WARM_W'(SYNC_STAGES + 1);
    end else if (bus.ce) begin
      r_prev <= w_s;
      if (r_warm != '0) r_warm <= r_warm - 1'b1;
    end
  end

  assign w_warm_done = (r_warm == '0);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic             w_rise;
    logic             w_fall;
    logic             w_det;
    logic [STR_W-1:0] r_str;
    logic             r_out;
    logic [CNT_W-1:0] r_cnt;

    assign w_rise = w_s[i] & ~r_prev[i];
    assign w_fall = ~w_s[i] & r_prev[i];
    assign w_det  = bus.ce & w_warm_done &
                    ((bus.mode[2*i] & w_rise) | (bus.mode[2*i+1] & w_fall));

    // A new detection reloads the stretch count, so back-to-back edges merge into one gapless pulse
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_str <= '0;
        r_out <= 1'b0;
      end else if (w_det) begin
        r_str <= STR_W'(STRETCH);
        r_out <= 1'b1;
      end else if (bus.ce && r_str != '0) begin
        r_str <= r_str - 1'b1;
        r_out <= (r_str != STR_W'(1));
      end
    end

    // Clear wins over a coincident detection, and neither depends on ce
    always_ff @(posedge clk) begin
      if (!rst_n || bus.cnt_clr) begin
        r_cnt <= '0;
      end else if (w_det && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign bus.out_x[i]                    = r_out;
    assign bus.edge_cnt[i*CNT_W +: CNT_W]  = r_cnt;
  end
endmodule

// File: tb/tb_edge_det_multi.sv
// Directed bench for edge_det_multi: three parameter sets driven from shared stimulus,
// a vector table for single-pulse/ce behaviour and hand sequences for multi-cycle cases.
module tb_edge_det_multi;
  typedef struct {
    logic        ce;
    logic [3:0]  inX;
    logic [7:0]  mode;
    logic        clr;
    logic [3:0]  expOut;
    logic [15:0] expCnt;
  } tbVec_t;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       ce = 1'b0;
  logic [3:0] inX = '0;
  logic [7:0] mode = '0;
  logic       cntClr = 1'b0;

  int checks = 0;
  int errors = 0;

  tbVec_t vec [22];

  always #5 clk = ~clk;

  edge_det_multi_if #(.NCH(4), .CNT_W(4)) ifA ();
  edge_det_multi_if #(.NCH(4), .CNT_W(8)) ifB ();
  edge_det_multi_if #(.NCH(4), .CNT_W(8)) ifC ();

  assign ifA.ce = ce;  assign ifA.in_x = inX;  assign ifA.mode = mode;  assign ifA.cnt_clr = cntClr;
  assign ifB.ce = ce;  assign ifB.in_x = inX;  assign ifB.mode = mode;  assign ifB.cnt_clr = cntClr;
  assign ifC.ce = ce;  assign ifC.in_x = inX;  assign ifC.mode = mode;  assign ifC.cnt_clr = cntClr;

  edge_det_multi #(.NCH(4), .SYNC_STAGES(2), .STRETCH(1), .CNT_W(4)) dutA (
    .clk(clk), .rst_n(rstN), .bus(ifA.slave));
  edge_det_multi #(.NCH(4), .SYNC_STAGES(2), .STRETCH(3), .CNT_W(8)) dutB (
    .clk(clk), .rst_n(rstN), .bus(ifB.slave));
  edge_det_multi #(.NCH(4), .SYNC_STAGES(0), .STRETCH(4), .CNT_W(8)) dutC (
    .clk(clk), .rst_n(rstN), .bus(ifC.slave));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then settle 1ns past it for sampling
  task automatic applyStimulus(input logic c, input logic [3:0] x, input logic [7:0] m, input logic clr);
    ce = c; inX = x; mode = m; cntClr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input logic [3:0] x, input logic [7:0] m);
    rstN = 1'b0;
    applyStimulus(1'b1, x, m, 1'b0);
    applyStimulus(1'b1, x, m, 1'b0);
    rstN = 1'b1;
  endtask

  initial begin
    vec[0]  = '{1'b1, 4'hE, 8'h01, 1'b0, 4'h0, 16'h0000};
    vec[1]  = '{1'b1, 4'hE, 8'h01, 1'b0, 4'h0, 16'h0000};
    vec[2]  = '{1'b1, 4'hE, 8'h01, 1'b0, 4'h0, 16'h0000};
    vec[3]  = '{1'b1, 4'hF, 8'h01, 1'b0, 4'h0, 16'h0000};
    vec[4]  = '{1'b1, 4'hF, 8'h01, 1'b0, 4'h0, 16'h0000};
    vec[5]  = '{1'b1, 4'hF, 8'h01, 1'b0, 4'h1, 16'h0001};
    vec[6]  = '{1'b1, 4'hF, 8'h01, 1'b0, 4'h0, 16'h0001};
    vec[7]  = '{1'b1, 4'hE, 8'h01, 1'b0, 4'h0, 16'h0001};
    vec[8]  = '{1'b1, 4'hE, 8'h01, 1'b0, 4'h0, 16'h0001};
    vec[9]  = '{1'b1, 4'hE, 8'h01, 1'b0, 4'h0, 16'h0001};
    vec[10] = '{1'b1, 4'hE, 8'h01, 1'b0, 4'h0, 16'h0001};
    vec[11] = '{1'b1, 4'hA, 8'h10, 1'b0, 4'h0, 16'h0001};
    vec[12] = '{1'b1, 4'hA, 8'h10, 1'b0, 4'h0, 16'h0001};
    vec[13] = '{1'b1, 4'hA, 8'h10, 1'b0, 4'h0, 16'h0001};
    vec[14] = '{1'b1, 4'hE, 8'h10, 1'b0, 4'h0, 16'h0001};
    vec[15] = '{1'b0, 4'hE, 8'h10, 1'b0, 4'h0, 16'h0001};
    vec[16] = '{1'b1, 4'hE, 8'h10, 1'b0, 4'h0, 16'h0001};
    vec[17] = '{1'b0, 4'hE, 8'h10, 1'b0, 4'h0, 16'h0001};
    vec[18] = '{1'b1, 4'hE, 8'h10, 1'b0, 4'h4, 16'h0101};
    vec[19] = '{1'b0, 4'hE, 8'h10, 1'b0, 4'h4, 16'h0101};
    vec[20] = '{1'b0, 4'hE, 8'h10, 1'b0, 4'h4, 16'h0101};
    vec[21] = '{1'b1, 4'hE, 8'h10, 1'b0, 4'h0, 16'h0101};

    // Level held high through reset release must never look like a rising edge
    rstN = 1'b0;
    applyStimulus(1'b1, 4'hF, 8'h55, 1'b0);
    applyStimulus(1'b1, 4'hF, 8'h55, 1'b0);
    checkOutput("reset_out", ifA.out_x, 4'h0);
    checkOutput("reset_cnt", ifA.edge_cnt, 16'h0000);
    rstN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 4'hF, 8'h55, 1'b0);
      checkOutput($sformatf("warmup_outA_%0d", i), ifA.out_x, 4'h0);
      checkOutput($sformatf("warmup_outB_%0d", i), ifB.out_x, 4'h0);
    end
    checkOutput("warmup_cntA", ifA.edge_cnt, 16'h0000);
    checkOutput("warmup_cntB", ifB.edge_cnt, 32'h0);

    // Single-pulse latency, ignored falling edge, ce-gated latency and hold
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vec[i].ce, vec[i].inX, vec[i].mode, vec[i].clr);
      checkOutput($sformatf("vec%0d_out", i), ifA.out_x, vec[i].expOut);
      checkOutput($sformatf("vec%0d_cnt", i), ifA.edge_cnt, vec[i].expCnt);
    end

    // Retrigger: ch1 in both-edge mode toggled every 2 cycles with STRETCH=3
    doReset(4'h0, 8'h0C);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'h0, 8'h0C, 1'b0);
    for (int c = 0; c < 14; c++) begin
      logic b;
      b = (c < 2) ? 1'b1 : (c < 4) ? 1'b0 : (c < 6) ? 1'b1 : 1'b0;
      applyStimulus(1'b1, {2'b00, b, 1'b0}, 8'h0C, 1'b0);
      checkOutput($sformatf("retrig_c%0d", c), ifB.out_x[1], (c >= 2 && c <= 10) ? 1 : 0);
    end
    checkOutput("retrig_cnt", ifB.edge_cnt[15:8], 8'd4);

    // Saturation of a 4-bit counter, then clear racing a detection
    doReset(4'h0, 8'h40);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'h0, 8'h40, 1'b0);
    for (int e = 0; e < 20; e++) begin
      applyStimulus(1'b1, 4'h8, 8'h40, 1'b0);
      applyStimulus(1'b1, 4'h8, 8'h40, 1'b0);
      applyStimulus(1'b1, 4'h0, 8'h40, 1'b0);
      applyStimulus(1'b1, 4'h0, 8'h40, 1'b0);
      if (e == 9) checkOutput("sat_mid_cnt", ifA.edge_cnt, 16'hA000);
    end
    applyStimulus(1'b1, 4'h0, 8'h40, 1'b0);
    applyStimulus(1'b1, 4'h0, 8'h40, 1'b0);
    checkOutput("sat_cnt", ifA.edge_cnt, 16'hF000);
    checkOutput("sat_idle_out", ifA.out_x, 4'h0);
    applyStimulus(1'b1, 4'h8, 8'h40, 1'b0);
    applyStimulus(1'b1, 4'h8, 8'h40, 1'b0);
    applyStimulus(1'b1, 4'h8, 8'h40, 1'b1);
    checkOutput("clr_det_out", ifA.out_x, 4'h8);
    checkOutput("clr_det_cnt", ifA.edge_cnt, 16'h0000);
    applyStimulus(1'b1, 4'h8, 8'h40, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'h0, 8'h40, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'h8, 8'h40, 1'b0);
    checkOutput("recount_cnt", ifA.edge_cnt, 16'h1000);
    applyStimulus(1'b0, 4'h8, 8'h40, 1'b1);
    checkOutput("clr_ce0_cnt", ifA.edge_cnt, 16'h0000);
    checkOutput("clr_ce0_out_hold", ifA.out_x, 4'h8);

    // Reset mid-stretch on the unsynchronised, STRETCH=4 instance
    doReset(4'h0, 8'h01);
    applyStimulus(1'b1, 4'h0, 8'h01, 1'b0);
    applyStimulus(1'b1, 4'h1, 8'h01, 1'b0);
    checkOutput("c_det_out", ifC.out_x, 4'h1);
    checkOutput("c_det_cnt", ifC.edge_cnt[7:0], 8'd1);
    applyStimulus(1'b1, 4'h1, 8'h01, 1'b0);
    rstN = 1'b0;
    applyStimulus(1'b0, 4'h1, 8'h01, 1'b0);
    checkOutput("c_rst_out", ifC.out_x, 4'h0);
    checkOutput("c_rst_cnt", ifC.edge_cnt, 32'h0);
    rstN = 1'b1;
    applyStimulus(1'b1, 4'h1, 8'h01, 1'b0);
    checkOutput("c_warm_out", ifC.out_x, 4'h0);
    applyStimulus(1'b1, 4'h1, 8'h01, 1'b0);
    checkOutput("c_warm_cnt", ifC.edge_cnt, 32'h0);
    applyStimulus(1'b1, 4'h0, 8'h01, 1'b0);
    applyStimulus(1'b1, 4'h1, 8'h01, 1'b0);
    checkOutput("c_resume_out", ifC.out_x, 4'h1);
    checkOutput("c_resume_cnt", ifC.edge_cnt[7:0], 8'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'h1, 8'h01, 1'b0);
      checkOutput($sformatf("c_stretch_%0d", i), ifC.out_x, 4'h1);
    end
    applyStimulus(1'b1, 4'h1, 8'h01, 1'b0);
    checkOutput("c_stretch_end", ifC.out_x, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/edge_det_multi.md
Name: edge_det_multi

Overview:
- Parametrised multi-channel successor to the single-bit clock-enabled edge detector.
- Each channel has an optional input synchroniser, a per-channel detect mode (off/rise/fall/both), a retriggerable output pulse stretcher and a saturating event counter.
- Sits between raw control/strobe inputs and the FIFO-side control logic, which consumes clean one-shot or stretched strobes and event counts.

Parameters:
- NCH, 4, number of independent channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (0 = input used directly, already in clk domain).
- STRETCH, 1, output pulse length in ce-qualified cycles (>=1).
- CNT_W, 8, width of each per-channel event counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- ce  input  1  clock enable; qualifies every state update except rst_n and cnt_clr.
- in_x  input  NCH  raw channel inputs, bit i = channel i.
- mode  input  2*NCH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- cnt_clr  input  1  synchronous clear of all event counters.
- out_x  output  NCH  registered edge pulses, stretched to STRETCH ce-cycles.
- edge_cnt  output  NCH*CNT_W  per-channel saturating edge counts, channel i at [(i+1)*CNT_W-1 : i*CNT_W].

Behaviour:
- Reset (rst_n=0 at clk edge, regardless of ce):
  - Synchroniser flops, prev-sample regs, stretch counters, out_x, edge_cnt all go to 0.
  - Warm-up counter loads SYNC_STAGES+1.
- Warm-up:
  - While warm-up counter is nonzero, each ce cycle decrements it and updates sync/prev normally, but detection is suppressed (no out_x, no count).
  - A level already high at reset release therefore never produces a spurious rising edge.
- ce=0: all registers hold (out_x holds its value; stretch does not advance). cnt_clr still acts.
- Sync path: s_i = last synchroniser stage, or in_x[i] when SYNC_STAGES=0. prev_i <= s_i each ce cycle.
- Detect (combinational, per channel):
  - rise = s & ~prev; fall = ~s & prev.
  - det = (mode[0]&rise) | (mode[1]&fall), qualified by ce and warm-up done.
- Latency: input transition sampled at ce-edge k produces out_x high after ce-edge k+SYNC_STAGES (SYNC_STAGES+1 ce-edges, inclusive); 1 edge when SYNC_STAGES=0.
- Stretcher:
  - On det, stretch counter loads STRETCH and out_x[i] is set at that same edge.
  - Each later ce cycle without det decrements the counter; out_x[i]=1 while the counter is nonzero after the update.
  - Retrigger: det while active reloads STRETCH, so there is no gap and the pulse lengthens.
  - STRETCH=1 gives exactly one ce-cycle pulse per edge.
- Mode:
  - Sampled every cycle; changes take effect in the same cycle.
  - Switching to 00 blocks new detections but does not truncate an active stretch.
- Counters:
  - edge_cnt_i increments by 1 on det_i and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 zeros all counters at the clk edge, ce-independent.
  - cnt_clr with simultaneous det: counter = 0 (the edge is not counted), but out_x still pulses.
- Channels are fully independent; simultaneous edges on all channels are all reported in the same cycle.
- Reset mid-pulse: out_x drops at the reset edge and the warm-up restarts.

Test Plan:
- NCH=4, SYNC=2, STRETCH=1, mode=all 01; hold in_x=4'hF through reset release -> no out_x during or after warm-up, edge_cnt all 0.
- ce=1, mode ch0=01; in_x[0] 0->1 before edge k -> out_x[0]=1 for exactly one cycle after edge k+2, edge_cnt[0]=1; the 1->0 transition gives no pulse.
- mode ch1=11, STRETCH=3; toggle in_x[1] every 2 cycles -> out_x[1] stays high continuously (retrigger); edge_cnt[1] = number of transitions.
- ce toggling 1,0,1,0 with a rising edge on ch2 (mode 01) -> latency counted in ce=1 edges only; out_x held through ce=0 cycles; still one count.
- CNT_W=4, 20 rising edges on ch3 -> edge_cnt[3]=15 (saturates); pulse cnt_clr in the same cycle as a detected edge -> edge_cnt[3]=0, out_x[3] still pulses.
- Mid-stretch (STRETCH=4), assert rst_n=0 for 1 cycle -> out_x=0 next edge, all counts 0, no detection for SYNC_STAGES+1 ce cycles.
